// File: rtl/lockable_reg_pkg.sv
// lockable_reg_pkg: shared types and default parameters for lockable_reg_bank.
// Holds the per-channel FSM state encoding and the default sizing constants.
package lockable_reg_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } ch_state_e;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_VIOL_CNT_W = 8;

endpackage

// File: rtl/lockable_reg_ch.sv
// lockable_reg_ch: one lockable data channel (lock FSM, data register, blocked-write detect).
// Ports: clk, reset (sync, active-high), data_in, wr, lock, bypass -> data_out, locked, blocked (comb).
module lockable_reg_ch
    import lockable_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr,
    input  logic              lock,
    input  logic              bypass,
    output logic [DATA_W-1:0] data_out,
    output logic              locked,
    output logic              blocked
);

    ch_state_e         state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UNLOCKED;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // LOCKED is absorbing; only reset leaves it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            UNLOCKED: if (lock) state_d = LOCKED;
            LOCKED:   state_d = LOCKED;
            default:  state_d = UNLOCKED;
        endcase
    end

    // Write is judged on the pre-edge state, so lock+write on an
    // unlocked channel still lands the data.
    always_comb begin
        accept  = wr && ((state_q == UNLOCKED) || bypass);
        blocked = wr && (state_q == LOCKED) && !bypass;
        data_d  = accept ? data_in : data_q;
    end

    assign data_out = data_q;
    assign locked   = (state_q == LOCKED);

endmodule

// File: rtl/lockable_reg_bank.sv
// lockable_reg_bank: NUM_CH sticky-lockable data registers with violation flags and a saturating counter.
// Ports: Clk, Reset (sync, active-high), Data_in, write, Lock, debug_unlocked, viol_clr ->
//        Data_out, lock_status, viol_flag, viol_count. Macro LOCKABLE_REG_BANK_DEBUG_UNLOCK_EN enables bypass.
module lockable_reg_bank
    import lockable_reg_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int VIOL_CNT_W = DEF_VIOL_CNT_W
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_CH*DATA_W-1:0] Data_in,
    input  logic [NUM_CH-1:0]        write,
    input  logic [NUM_CH-1:0]        Lock,
    input  logic                     debug_unlocked,
    input  logic                     viol_clr,
    output logic [NUM_CH*DATA_W-1:0] Data_out,
    output logic [NUM_CH-1:0]        lock_status,
    output logic [NUM_CH-1:0]        viol_flag,
    output logic [VIOL_CNT_W-1:0]    viol_count
);

    // Wide enough for count + popcount of up to 32 channels.
    localparam int SUM_W = VIOL_CNT_W + 6;

    logic                  bypass;
    logic [NUM_CH-1:0]     blocked;
    logic [NUM_CH-1:0]     flag_q, flag_d;
    logic [VIOL_CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0]      pop;
    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      cnt_max;

`ifdef LOCKABLE_REG_BANK_DEBUG_UNLOCK_EN
    assign bypass = debug_unlocked;
`else
    // Production build: debug_unlocked reaches no register.
    logic unused_debug;
    assign unused_debug = debug_unlocked;
    assign bypass       = 1'b0;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        lockable_reg_ch #(
            .DATA_W (DATA_W)
        ) u_ch (
            .clk      (Clk),
            .reset    (Reset),
            .data_in  (Data_in[c*DATA_W +: DATA_W]),
            .wr       (write[c]),
            .lock     (Lock[c]),
            .bypass   (bypass),
            .data_out (Data_out[c*DATA_W +: DATA_W]),
            .locked   (lock_status[c]),
            .blocked  (blocked[c])
        );
    end

    always_comb begin
        pop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pop = pop + SUM_W'(blocked[c]);
        end
    end

    // A clear still counts blocks from the same cycle.
    always_comb begin
        cnt_max = SUM_W'({VIOL_CNT_W{1'b1}});
        sum     = (viol_clr ? '0 : SUM_W'(cnt_q)) + pop;
        cnt_d   = (sum > cnt_max) ? {VIOL_CNT_W{1'b1}} : sum[VIOL_CNT_W-1:0];
        flag_d  = viol_clr ? blocked : (flag_q | blocked);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q  <= '0;
            flag_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign viol_count = cnt_q;
    assign viol_flag  = flag_q;

endmodule

// File: tb/tb_lockable_reg_bank.sv
// tb_lockable_reg_bank: directed self-checking bench for lockable_reg_bank
// with NUM_CH=2, DATA_W=16, VIOL_CNT_W=4.
module tb_lockable_reg_bank;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Data_in;
    logic [1:0]  write;
    logic [1:0]  Lock;
    logic        debug_unlocked;
    logic        viol_clr;
    logic [31:0] Data_out;
    logic [1:0]  lock_status;
    logic [1:0]  viol_flag;
    logic [3:0]  viol_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt;

    always #5 Clk = ~Clk;

    lockable_reg_bank #(
        .NUM_CH     (2),
        .DATA_W     (16),
        .VIOL_CNT_W (4)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Data_in        (Data_in),
        .write          (write),
        .Lock           (Lock),
        .debug_unlocked (debug_unlocked),
        .viol_clr       (viol_clr),
        .Data_out       (Data_out),
        .lock_status    (lock_status),
        .viol_flag      (viol_flag),
        .viol_count     (viol_count)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        write    = 2'b00;
        Lock     = 2'b00;
        viol_clr = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Data_in = 32'hFFFF_FFFF;
        write = 2'b11;
        Lock = 2'b11;
        viol_clr = 1'b0;
        debug_unlocked = 1'b0;
        step();
        step();
        checks++;
        if (Data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h want %h", Data_out, 32'h0);
        end
        checks++;
        if (lock_status !== 2'b00) begin
            errors++;
            $display("FAIL reset_lock got %b want 00", lock_status);
        end
        checks++;
        if (viol_flag !== 2'b00) begin
            errors++;
            $display("FAIL reset_flag got %b want 00", viol_flag);
        end
        checks++;
        if (viol_count !== 4'h0) begin
            errors++;
            $display("FAIL reset_count got %h want 0", viol_count);
        end
        Reset = 1'b0;
        idle();
        step();
    endtask

    task automatic test_write_unlocked();
        Data_in = {16'h5A5A, 16'hA5A5};
        write = 2'b11;
        step();
        idle();
        checks++;
        if (Data_out !== {16'h5A5A, 16'hA5A5}) begin
            errors++;
            $display("FAIL wr_unlocked got %h want %h", Data_out, {16'h5A5A, 16'hA5A5});
        end
        checks++;
        if (lock_status !== 2'b00 || viol_count !== 4'h0) begin
            errors++;
            $display("FAIL wr_unlocked_stat got %b/%h want 00/0", lock_status, viol_count);
        end
        Data_in = 32'hDEAD_BEEF;
        step();
        checks++;
        if (Data_out !== {16'h5A5A, 16'hA5A5}) begin
            errors++;
            $display("FAIL hold_nowrite got %h want %h", Data_out, {16'h5A5A, 16'hA5A5});
        end
    endtask

    task automatic test_lock_write();
        Data_in = {16'h0000, 16'h1234};
        write = 2'b01;
        Lock = 2'b01;
        step();
        idle();
        checks++;
        if (Data_out[15:0] !== 16'h1234 || lock_status !== 2'b01) begin
            errors++;
            $display("FAIL lock_same_cycle got %h/%b want 1234/01", Data_out[15:0], lock_status);
        end
        Data_in = {16'h0000, 16'hBEEF};
        write = 2'b01;
        step();
        idle();
        checks++;
        if (Data_out !== {16'h5A5A, 16'h1234}) begin
            errors++;
            $display("FAIL blocked_hold got %h want %h", Data_out, {16'h5A5A, 16'h1234});
        end
        checks++;
        if (viol_flag !== 2'b01 || viol_count !== 4'h1) begin
            errors++;
            $display("FAIL blocked_viol got %b/%h want 01/1", viol_flag, viol_count);
        end
        exp_cnt = 1;
    endtask

    task automatic test_debug_bypass();
        Lock = 2'b10;
        step();
        idle();
        checks++;
        if (lock_status !== 2'b11) begin
            errors++;
            $display("FAIL lock_ch1 got %b want 11", lock_status);
        end
        debug_unlocked = 1'b1;
        Data_in = {16'h00FF, 16'h00FF};
        write = 2'b11;
        step();
        idle();
        debug_unlocked = 1'b0;
`ifdef LOCKABLE_REG_BANK_DEBUG_UNLOCK_EN
        checks++;
        if (Data_out !== {16'h00FF, 16'h00FF} || viol_count !== 4'h1) begin
            errors++;
            $display("FAIL bypass got %h/%h want 00ff00ff/1", Data_out, viol_count);
        end
        exp_cnt = 1;
`else
        checks++;
        if (Data_out !== {16'h5A5A, 16'h1234} || viol_count !== 4'h3) begin
            errors++;
            $display("FAIL no_bypass got %h/%h want 5a5a1234/3", Data_out, viol_count);
        end
        exp_cnt = 3;
`endif
    endtask

    task automatic test_saturation();
        logic [31:0] held;
        held = Data_out;
        for (int i = 0; i < 20; i++) begin
            Data_in = {16'(i), 16'(i + 100)};
            write = 2'b11;
            step();
            exp_cnt = (exp_cnt + 2 > 15) ? 15 : exp_cnt + 2;
            checks++;
            if (viol_count !== 4'(exp_cnt)) begin
                errors++;
                $display("FAIL sat_step%0d got %h want %h", i, viol_count, 4'(exp_cnt));
            end
        end
        idle();
        checks++;
        if (viol_count !== 4'hF || viol_flag !== 2'b11) begin
            errors++;
            $display("FAIL sat_final got %h/%b want f/11", viol_count, viol_flag);
        end
        checks++;
        if (Data_out !== held) begin
            errors++;
            $display("FAIL sat_hold got %h want %h", Data_out, held);
        end
    endtask

    task automatic test_clr_with_block();
        viol_clr = 1'b1;
        write = 2'b10;
        step();
        idle();
        checks++;
        if (viol_count !== 4'h1 || viol_flag !== 2'b10) begin
            errors++;
            $display("FAIL clr_block got %h/%b want 1/10", viol_count, viol_flag);
        end
        viol_clr = 1'b1;
        step();
        idle();
        checks++;
        if (viol_count !== 4'h0 || viol_flag !== 2'b00) begin
            errors++;
            $display("FAIL clr_only got %h/%b want 0/00", viol_count, viol_flag);
        end
    endtask

    task automatic test_reset_mid();
        Reset = 1'b1;
        Lock = 2'b10;
        write = 2'b10;
        Data_in = 32'h9999_9999;
        step();
        Reset = 1'b0;
        idle();
        checks++;
        if (Data_out !== 32'h0 || lock_status !== 2'b00
            || viol_flag !== 2'b00 || viol_count !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid got %h/%b/%b/%h want 0/00/00/0",
                     Data_out, lock_status, viol_flag, viol_count);
        end
        Data_in = {16'h7777, 16'h0000};
        write = 2'b10;
        step();
        idle();
        checks++;
        if (Data_out !== {16'h7777, 16'h0000} || lock_status !== 2'b00
            || viol_count !== 4'h0) begin
            errors++;
            $display("FAIL post_reset_wr got %h/%b/%h want 77770000/00/0",
                     Data_out, lock_status, viol_count);
        end
    endtask

    task automatic test_back_to_back();
        Data_in = {16'h1111, 16'h2222};
        write = 2'b11;
        step();
        Data_in = {16'h3333, 16'h4444};
        step();
        idle();
        checks++;
        if (Data_out !== {16'h3333, 16'h4444}) begin
            errors++;
            $display("FAIL b2b got %h want 33334444", Data_out);
        end
    endtask

    initial begin
        exp_cnt = 0;
        test_reset();
        test_write_unlocked();
        test_lock_write();
        test_debug_bypass();
        test_saturation();
        test_clr_with_block();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
